mips32_state_dump: RTL
======================

MIPS32_STATE_DUMP -- requirements
Module: mips32_state_dump

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of register/memory words and out_data.
REQ-002 SHALL have parameter REG_DEPTH, default 32, register-file entries scanned; REG_AW = $clog2(REG_DEPTH).
REQ-003 SHALL have parameter MEM_DEPTH, default 32, data-memory words scanned; MEM_AW = $clog2(MEM_DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-007 SHALL have port halt_cpu  output  1  freezes CPU state while high.
REQ-008 SHALL have port reg_rd_addr  output  REG_AW  register-file read address (combinational read).
REQ-009 SHALL have port reg_rd_data  input  DATA_W  register-file read data.
REQ-010 SHALL have port mem_rd_addr  output  MEM_AW  data-memory word read address (combinational read).
REQ-011 SHALL have port mem_rd_data  input  DATA_W  data-memory read data.
REQ-012 SHALL have ports out_valid output 1, out_ready input 1, out_data output DATA_W, out_src output 1 (0=register, 1=memory), out_last output 1: registered output stream.
REQ-013 SHALL have ports busy output 1 (state != IDLE) and done output 1 (one-cycle completion pulse).

Function
REQ-014 SHALL implement states IDLE, REG_SCAN, MEM_SCAN, DRAIN.
REQ-015 IDLE: start=1 at an edge SHALL move to REG_SCAN with scan index 0; halt_cpu high from that edge until return to IDLE.
REQ-016 Output slot SHALL be free when !out_valid or (out_valid and out_ready); a word transfers on out_valid and out_ready at an edge.
REQ-017 In REG_SCAN/MEM_SCAN, with the slot free, the block SHALL register rd_data at the current index into out_data, set out_valid, set out_src, and increment the index at that edge.
REQ-018 With the slot not free, out_data, out_src, out_last and the index SHALL hold unchanged.
REQ-019 Loading index REG_DEPTH-1 in REG_SCAN SHALL move to MEM_SCAN with index 0.
REQ-020 Loading index MEM_DEPTH-1 in MEM_SCAN SHALL set out_last and move to DRAIN.
REQ-021 DRAIN: on transfer of the out_last word, the block SHALL clear out_valid/out_last, pulse done for one cycle and return to IDLE.
REQ-022 With out_ready held high, throughput SHALL be one word per cycle; the first word SHALL be valid one cycle after entering REG_SCAN.
REQ-023 start while busy SHALL be ignored; start and completion at the same edge SHALL NOT begin a new dump (start must be re-sampled in IDLE).
REQ-024 Index counters SHALL never exceed DEPTH-1; non-power-of-two depths SHALL stop at DEPTH-1, not at the counter wrap.
REQ-025 reg_rd_addr/mem_rd_addr SHALL equal the current index in their scan state and 0 otherwise.

Reset
REQ-026 rst high SHALL immediately force IDLE, indices 0, out_valid/out_last/out_src/done/halt_cpu/busy 0, out_data 0, including mid-dump; no partial stream resumes after reset.

Configuration
REQ-027 Macro DUMP_CHECKSUM_EN defined: after the last memory word, one extra word SHALL be emitted, equal to the XOR of all dumped words, with out_src=1 and out_last on it only; undefined: no extra word and out_last on memory word MEM_DEPTH-1.

Verification
REQ-028 Regs r[i]=i, mem[j]=0x100+j, defaults, out_ready=1, start one cycle -> 64 words 0..31 then 0x100..0x11F, out_src 0 then 1, out_last on word 64, done one cycle later.
REQ-029 Same, out_ready toggling 1,0 -> identical sequence, no duplicates or drops, out_data stable while stalled, halt_cpu high throughout.
REQ-030 rst asserted after 10 transfers -> all outputs 0 at once; a new start yields a full stream from r[0].
REQ-031 start pulsed repeatedly during a dump -> exactly one 64-word stream and one done pulse.
REQ-032 REG_DEPTH=5, MEM_DEPTH=3 -> 8 words, indices stop at 4 and 2.
REQ-033 DUMP_CHECKSUM_EN defined, REQ-028 data -> 65th word = XOR of all 64 words, out_last only on it.

Source files
------------

// File: rtl/mips32_state_dump_if.sv
// Bus bundle for the CPU state dumper: control, register/memory read ports and output stream.
// master = dump engine side, slave = CPU/consumer side.
interface mips32_state_dump_if #(
   parameter int DATA_W    = 32,
   parameter int REG_DEPTH = 32,
   parameter int MEM_DEPTH = 32
);
   localparam int REG_AW = $clog2(REG_DEPTH);
   localparam int MEM_AW = $clog2(MEM_DEPTH);

   logic              start;
   logic              halt_cpu;
   logic [REG_AW-1:0] reg_rd_addr;
   logic [DATA_W-1:0] reg_rd_data;
   logic [MEM_AW-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_src;
   logic              out_last;
   logic              busy;
   logic              done;

   modport master (
      input  start, reg_rd_data, mem_rd_data, out_ready,
      output halt_cpu, reg_rd_addr, mem_rd_addr, out_valid, out_data, out_src, out_last, busy, done
   );

   modport slave (
      output start, reg_rd_data, mem_rd_data, out_ready,
      input  halt_cpu, reg_rd_addr, mem_rd_addr, out_valid, out_data, out_src, out_last, busy, done
   );
endinterface

// File: rtl/mips32_state_dump.sv
// Freezes the CPU and streams every register then every data-memory word out a ready/valid port.
// Optional DUMP_CHECKSUM_EN appends one XOR-of-all-words trailer word marked out_last.
//
// state    | meaning
// IDLE     | waiting for start, CPU running
// REG_SCAN | loading register-file words into the output slot
// MEM_SCAN | loading data-memory words into the output slot
// DRAIN    | waiting for the out_last word to be accepted
module mips32_state_dump #(
   parameter int DATA_W    = 32,
   parameter int REG_DEPTH = 32,
   parameter int MEM_DEPTH = 32
) (
   input logic clk,
   input logic rst,
   mips32_state_dump_if.master bus
);
   localparam int REG_AW = $clog2(REG_DEPTH);
   localparam int MEM_AW = $clog2(MEM_DEPTH);
   localparam logic [REG_AW-1:0] REG_LAST = REG_AW'(REG_DEPTH - 1);
   localparam logic [MEM_AW-1:0] MEM_LAST = MEM_AW'(MEM_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, REG_SCAN, MEM_SCAN, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [REG_AW-1:0] reg_idx;
   logic [MEM_AW-1:0] mem_idx;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q, out_src_q, out_last_q, done_q;
   logic              slot_free, xfer_last;
`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   assign slot_free = !out_valid_q || bus.out_ready;
   assign xfer_last = out_valid_q && bus.out_ready && out_last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (bus.start) state_nxt = REG_SCAN;
         REG_SCAN: if (slot_free && reg_idx == REG_LAST) state_nxt = MEM_SCAN;
         MEM_SCAN: if (slot_free && mem_idx == MEM_LAST) state_nxt = DRAIN;
         DRAIN:    if (xfer_last) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy        = (state != IDLE);
      bus.halt_cpu    = (state != IDLE);
      bus.reg_rd_addr = (state == REG_SCAN) ? reg_idx : '0;
      bus.mem_rd_addr = (state == MEM_SCAN) ? mem_idx : '0;
   end

   // Indices saturate at their last entry so non-power-of-two depths never wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_idx     <= '0;
         mem_idx     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_src_q   <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               reg_idx <= '0;
               mem_idx <= '0;
`ifdef DUMP_CHECKSUM_EN
               csum    <= '0;
`endif
            end
            REG_SCAN: if (slot_free) begin
               out_data_q  <= bus.reg_rd_data;
               out_valid_q <= 1'b1;
               out_src_q   <= 1'b0;
               out_last_q  <= 1'b0;
               if (reg_idx != REG_LAST) reg_idx <= reg_idx + REG_AW'(1);
`ifdef DUMP_CHECKSUM_EN
               csum        <= csum ^ bus.reg_rd_data;
`endif
            end
            MEM_SCAN: if (slot_free) begin
               out_data_q  <= bus.mem_rd_data;
               out_valid_q <= 1'b1;
               out_src_q   <= 1'b1;
               if (mem_idx != MEM_LAST) mem_idx <= mem_idx + MEM_AW'(1);
`ifdef DUMP_CHECKSUM_EN
               out_last_q  <= 1'b0;
               csum        <= csum ^ bus.mem_rd_data;
`else
               out_last_q  <= (mem_idx == MEM_LAST);
`endif
            end
            DRAIN: begin
               if (xfer_last) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  done_q      <= 1'b1;
               end
`ifdef DUMP_CHECKSUM_EN
               else if (slot_free && !out_last_q) begin
                  out_data_q  <= csum;
                  out_valid_q <= 1'b1;
                  out_src_q   <= 1'b1;
                  out_last_q  <= 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_src   = out_src_q;
   assign bus.out_last  = out_last_q;
   assign bus.done      = done_q;
endmodule
